clk_rst_seq: RTL and testbench

Synthesizable clock-enable and reset sequencer for the sc_computer platform. It generalises the fixed CPU clock / memory clock / reset pattern into NUM_CH programmable clock-enable channels, each with its own divisor and phase. It stretches a downstream core reset over a programmable number of channel-0 periods, and adds run/halt/single-step gating for debug. It sits between the board clock and the CPU/memory clock-enable inputs.

---
 rtl/clk_rst_pkg.sv | 13 +
 rtl/clk_div_ch.sv | 46 ++++
 rtl/clk_rst_seq.sv | 87 ++++++++
 tb/tb_clk_rst_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// Shared types and helpers for the clock-enable / reset sequencer.
package clk_rst_pkg;

  localparam int DIV_W_DEF = 8;

  typedef enum logic [1:0] {RST_HOLD, RUN, HALT, STEP} state_t;

  // Width of a counter that must reach 'cycles' inclusive.
  function automatic int rst_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One clock-enable channel: free-running divider counter, phase match, gated ce strobe and tick.
module clk_div_ch
  import clk_rst_pkg::*;
#(
  parameter int               DIV_W   = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DIV_RST = '0
)(
  input  logic             clock,
  input  logic             reset,
  input  logic             gate,
  input  logic             load,
  input  logic [DIV_W-1:0] ld_div,
  input  logic [DIV_W-1:0] ld_phase,
  output logic             hit,
  output logic             ce,
  output logic             tick
);

  logic [DIV_W-1:0] div, phase, cnt;
  logic             ce_nxt;

  assign hit    = (cnt == phase);
  assign ce_nxt = gate && hit;

  // The counter ignores gate so phase alignment survives a halt.
  always_ff @(posedge clock) begin
    if (reset) begin
      div   <= DIV_RST;
      phase <= '0;
      cnt   <= '0;
      ce    <= 1'b0;
      tick  <= 1'b1;
    end else begin
      ce   <= ce_nxt;
      tick <= tick ^ ce_nxt;
      if (load) begin
        div   <= ld_div;
        phase <= (ld_phase > ld_div) ? ld_div : ld_phase;
        cnt   <= '0;
      end else begin
        cnt <= (cnt == div) ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_rst_seq.sv
// Programmable clock-enable channels with stretched core reset and run/halt/step gating.
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int                      NUM_CH     = 2,
  parameter int                      DIV_W      = DIV_W_DEF,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT   = {8'd0, 8'd1},
  parameter int                      RST_CYCLES = 16,
  localparam int                     CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic              run,
  input  logic              step,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] tick,
  output logic              core_rst,
  output logic              halted
);

  localparam int                RC_W = rst_cnt_w(RST_CYCLES);
  localparam logic [NUM_CH-1:0] CH0  = NUM_CH'(1);

  state_t            state, state_nxt;
  logic [RC_W-1:0]   rst_cnt, rst_cnt_nxt;
  logic              gate, step_hit;
  logic [NUM_CH-1:0] hit;

  assign gate     = (state != HALT);
  // Channel 0 phase match with an open gate is exactly "ce[0] issues on this edge".
  assign step_hit = |(hit & CH0);

  // Channel selects that do not exist simply never match.
  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      clk_div_ch #(
        .DIV_W   (DIV_W),
        .DIV_RST (DIV_INIT[c*DIV_W +: DIV_W])
      ) u_ch (
        .clock    (clock),
        .reset    (reset),
        .gate     (gate),
        .load     (cfg_we && (cfg_ch == CH_W'(c))),
        .ld_div   (cfg_div),
        .ld_phase (cfg_phase),
        .hit      (hit[c]),
        .ce       (ce[c]),
        .tick     (tick[c])
      );
    end
  endgenerate

  always_comb begin
    state_nxt   = state;
    rst_cnt_nxt = rst_cnt;
    case (state)
      RST_HOLD: if (ce[0]) begin
        rst_cnt_nxt = rst_cnt + 1'b1;
        if (rst_cnt == RC_W'(RST_CYCLES - 1)) state_nxt = run ? RUN : HALT;
      end
      RUN:      if (!run) state_nxt = HALT;
      HALT:     if (run) state_nxt = RUN;
                else if (step) state_nxt = STEP;
      STEP:     if (step_hit) state_nxt = run ? RUN : HALT;
      default:  state_nxt = RST_HOLD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RST_HOLD;
      rst_cnt  <= '0;
      core_rst <= 1'b1;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      rst_cnt  <= rst_cnt_nxt;
      core_rst <= (state_nxt == RST_HOLD);
      halted   <= (state_nxt == HALT);
    end
  end

endmodule

// File: tb/tb_clk_rst_seq.sv
// Scoreboard bench: expectations derived from the edge-timing rules, queued per edge and popped after it.
module tb_clk_rst_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default 2-channel instance
  logic       reset, cfg_we, cfg_ch, run, step;
  logic [7:0] cfg_div, cfg_phase;
  logic [1:0] ce, tick;
  logic       core_rst, halted;

  // auxiliary 4- and 3-channel instances
  logic       areset, a_run, a_step, z_we, a_we;
  logic [1:0] z_ch, a_ch;
  logic [3:0] z_div, z_phase, a_div, a_phase;
  logic [3:0] ce4, tick4;
  logic       core_rst4, halted4;
  logic [2:0] ce3, tick3;
  logic       core_rst3, halted3;

  clk_rst_seq dut (
    .clock(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_phase(cfg_phase), .run(run), .step(step), .ce(ce), .tick(tick),
    .core_rst(core_rst), .halted(halted));

  clk_rst_seq #(.NUM_CH(4), .DIV_W(4), .DIV_INIT(16'h0), .RST_CYCLES(1)) dut4 (
    .clock(clk), .reset(areset), .cfg_we(z_we), .cfg_ch(z_ch), .cfg_div(z_div),
    .cfg_phase(z_phase), .run(a_run), .step(a_step), .ce(ce4), .tick(tick4),
    .core_rst(core_rst4), .halted(halted4));

  clk_rst_seq #(.NUM_CH(3), .DIV_W(4), .DIV_INIT(12'h0), .RST_CYCLES(1)) dut3 (
    .clock(clk), .reset(areset), .cfg_we(a_we), .cfg_ch(a_ch), .cfg_div(a_div),
    .cfg_phase(a_phase), .run(a_run), .step(a_step), .ce(ce3), .tick(tick3),
    .core_rst(core_rst3), .halted(halted3));

  typedef struct {
    logic [3:0] ce;
    logic [3:0] tick;
    logic       core_rst;
    logic       halted;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad   = 0;
  logic [3:0] tick_m;

  // ch0 after the div=2 phase=5(->2) write at edge 52; ch1 after div=3 phase=2 write at edge 40
  function automatic logic f0(input int n);
    return ((n - 53) % 3) == 2;
  endfunction
  function automatic logic f1(input int n);
    return ((n - 41) % 4) == 2;
  endfunction

  task automatic test_reset();
    exp_t e;
    logic [3:0] c;
    reset = 1'b1; run = 1'b1; step = 1'b0; cfg_we = 1'b0;
    cfg_ch = 1'b0; cfg_div = 8'd0; cfg_phase = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    tick_m = 4'hf;
    q.push_back('{4'h0, tick_m, 1'b1, 1'b0});
    e = q.pop_front(); total++;
    if ({ce, tick, core_rst, halted} !== {e.ce[1:0], e.tick[1:0], e.core_rst, e.halted}) begin
      bad++;
      $display("FAIL reset_values: got ce=%b tick=%b core_rst=%b halted=%b, want ce=%b tick=%b core_rst=%b halted=%b",
               ce, tick, core_rst, halted, e.ce[1:0], e.tick[1:0], e.core_rst, e.halted);
    end
    reset = 1'b0;
    for (int n = 1; n <= 34; n++) begin
      c = {2'b00, 1'b1, n[0]};
      tick_m ^= c;
      q.push_back('{c, tick_m, n < 32, 1'b0});
      @(posedge clk); #1;
      e = q.pop_front(); total++;
      if ({ce, tick, core_rst, halted} !== {e.ce[1:0], e.tick[1:0], e.core_rst, e.halted}) begin
        bad++;
        $display("FAIL reset_hold edge %0d: got ce=%b tick=%b core_rst=%b halted=%b, want ce=%b tick=%b core_rst=%b halted=%b",
                 n, ce, tick, core_rst, halted, e.ce[1:0], e.tick[1:0], e.core_rst, e.halted);
      end
    end
  endtask

  task automatic test_cfg_ch1();
    exp_t e;
    logic [3:0] c;
    for (int n = 35; n <= 51; n++) begin
      cfg_we = (n == 40); cfg_ch = 1'b1; cfg_div = 8'd3; cfg_phase = 8'd2;
      c = '0;
      c[0] = n[0];
      c[1] = (n <= 40) ? 1'b1 : f1(n);
      tick_m ^= c;
      q.push_back('{c, tick_m, 1'b0, 1'b0});
      @(posedge clk); #1;
      e = q.pop_front(); total++;
      if ({ce, tick, core_rst, halted} !== {e.ce[1:0], e.tick[1:0], e.core_rst, e.halted}) begin
        bad++;
        $display("FAIL cfg_ch1 edge %0d: got ce=%b tick=%b core_rst=%b halted=%b, want ce=%b tick=%b core_rst=%b halted=%b",
                 n, ce, tick, core_rst, halted, e.ce[1:0], e.tick[1:0], e.core_rst, e.halted);
      end
    end
    cfg_we = 1'b0;
  endtask

  task automatic test_cfg_clamp();
    exp_t e;
    logic [3:0] c;
    for (int n = 52; n <= 59; n++) begin
      cfg_we = (n == 52); cfg_ch = 1'b0; cfg_div = 8'd2; cfg_phase = 8'd5;
      c = '0;
      c[0] = (n <= 52) ? n[0] : f0(n);
      c[1] = f1(n);
      tick_m ^= c;
      q.push_back('{c, tick_m, 1'b0, 1'b0});
      @(posedge clk); #1;
      e = q.pop_front(); total++;
      if ({ce, tick, core_rst, halted} !== {e.ce[1:0], e.tick[1:0], e.core_rst, e.halted}) begin
        bad++;
        $display("FAIL cfg_clamp edge %0d: got ce=%b tick=%b core_rst=%b halted=%b, want ce=%b tick=%b core_rst=%b halted=%b",
                 n, ce, tick, core_rst, halted, e.ce[1:0], e.tick[1:0], e.core_rst, e.halted);
      end
    end
    cfg_we = 1'b0;
  endtask

  // HALT after 60..70, STEP after 71..72, HALT after 73..81, RUN from 82 (run+step together)
  task automatic test_halt_step();
    exp_t e;
    logic [3:0] c;
    logic open, h;
    for (int n = 60; n <= 90; n++) begin
      run  = !(n >= 60 && n <= 81);
      step = (n == 71) || (n == 82);
      open = !((n >= 61 && n <= 71) || (n >= 74 && n <= 82));
      h    = (n >= 60 && n <= 70) || (n >= 73 && n <= 81);
      c = '0;
      c[0] = open && f0(n);
      c[1] = open && f1(n);
      tick_m ^= c;
      q.push_back('{c, tick_m, 1'b0, h});
      @(posedge clk); #1;
      e = q.pop_front(); total++;
      if ({ce, tick, core_rst, halted} !== {e.ce[1:0], e.tick[1:0], e.core_rst, e.halted}) begin
        bad++;
        $display("FAIL halt_step edge %0d: got ce=%b tick=%b core_rst=%b halted=%b, want ce=%b tick=%b core_rst=%b halted=%b",
                 n, ce, tick, core_rst, halted, e.ce[1:0], e.tick[1:0], e.core_rst, e.halted);
      end
    end
    step = 1'b0;
  endtask

  // halt at 91, step at 92, reset at 93 while in STEP; then reset again at hold edge 10
  task automatic test_reset_mid();
    exp_t e;
    logic [3:0] c;
    for (int n = 91; n <= 93; n++) begin
      run = 1'b0; step = (n == 92); reset = (n == 93);
      c = '0;
      if (n == 91) begin
        c[0] = f0(n); c[1] = f1(n);
        tick_m ^= c;
        q.push_back('{c, tick_m, 1'b0, 1'b1});
      end else if (n == 92) begin
        q.push_back('{c, tick_m, 1'b0, 1'b0});
      end else begin
        tick_m = 4'hf;
        q.push_back('{c, tick_m, 1'b1, 1'b0});
      end
      @(posedge clk); #1;
      e = q.pop_front(); total++;
      if ({ce, tick, core_rst, halted} !== {e.ce[1:0], e.tick[1:0], e.core_rst, e.halted}) begin
        bad++;
        $display("FAIL reset_in_step edge %0d: got ce=%b tick=%b core_rst=%b halted=%b, want ce=%b tick=%b core_rst=%b halted=%b",
                 n, ce, tick, core_rst, halted, e.ce[1:0], e.tick[1:0], e.core_rst, e.halted);
      end
    end
    step = 1'b0; run = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      reset = (n == 10);
      if (n == 10) begin
        tick_m = 4'hf;
        c = '0;
      end else begin
        c = {2'b00, 1'b1, n[0]};
        tick_m ^= c;
      end
      q.push_back('{c, tick_m, 1'b1, 1'b0});
      @(posedge clk); #1;
      e = q.pop_front(); total++;
      if ({ce, tick, core_rst, halted} !== {e.ce[1:0], e.tick[1:0], e.core_rst, e.halted}) begin
        bad++;
        $display("FAIL reset_in_hold edge %0d: got ce=%b tick=%b core_rst=%b halted=%b, want ce=%b tick=%b core_rst=%b halted=%b",
                 n, ce, tick, core_rst, halted, e.ce[1:0], e.tick[1:0], e.core_rst, e.halted);
      end
    end
    reset = 1'b0;
    for (int n = 1; n <= 34; n++) begin
      c = {2'b00, 1'b1, n[0]};
      tick_m ^= c;
      q.push_back('{c, tick_m, n < 32, 1'b0});
      @(posedge clk); #1;
      e = q.pop_front(); total++;
      if ({ce, tick, core_rst, halted} !== {e.ce[1:0], e.tick[1:0], e.core_rst, e.halted}) begin
        bad++;
        $display("FAIL rehold edge %0d: got ce=%b tick=%b core_rst=%b halted=%b, want ce=%b tick=%b core_rst=%b halted=%b",
                 n, ce, tick, core_rst, halted, e.ce[1:0], e.tick[1:0], e.core_rst, e.halted);
      end
    end
  endtask

  task automatic test_four_ch();
    exp_t e;
    logic [3:0] ta;
    areset = 1'b1; a_run = 1'b1; a_step = 1'b0;
    z_we = 1'b0; z_ch = 2'd0; z_div = 4'd0; z_phase = 4'd0;
    a_we = 1'b0; a_ch = 2'd0; a_div = 4'd0; a_phase = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    ta = 4'hf;
    for (int n = 0; n <= 6; n++) begin
      if (n > 0) begin
        areset = 1'b0;
        ta ^= 4'hf;
      end
      q.push_back('{(n == 0) ? 4'h0 : 4'hf, ta, n < 2, 1'b0});
      q.push_back('{(n == 0) ? 4'h0 : 4'h7, 4'h0, n < 2, 1'b0});
      if (n > 0) begin
        @(posedge clk); #1;
      end
      e = q.pop_front(); total++;
      if ({ce4, tick4, core_rst4, halted4} !== {e.ce, e.tick, e.core_rst, e.halted}) begin
        bad++;
        $display("FAIL four_ch edge %0d: got ce=%b tick=%b core_rst=%b halted=%b, want ce=%b tick=%b core_rst=%b halted=%b",
                 n, ce4, tick4, core_rst4, halted4, e.ce, e.tick, e.core_rst, e.halted);
      end
      e = q.pop_front(); total++;
      if ({ce3, core_rst3, halted3} !== {e.ce[2:0], e.core_rst, e.halted}) begin
        bad++;
        $display("FAIL three_ch edge %0d: got ce=%b core_rst=%b halted=%b, want ce=%b core_rst=%b halted=%b",
                 n, ce3, core_rst3, halted3, e.ce[2:0], e.core_rst, e.halted);
      end
    end
  endtask

  // write to nonexistent ch3 at edge 7 (ignored), then a real write to ch2 at edge 12
  task automatic test_bad_ch();
    exp_t e;
    logic [3:0] c;
    for (int n = 7; n <= 16; n++) begin
      a_we    = (n == 7) || (n == 12);
      a_ch    = (n == 7) ? 2'd3 : 2'd2;
      a_div   = (n == 7) ? 4'd5 : 4'd1;
      a_phase = 4'd0;
      c = 4'b0011;
      c[2] = (n <= 12) ? 1'b1 : (((n - 13) % 2) == 0);
      q.push_back('{c, 4'h0, 1'b0, 1'b0});
      @(posedge clk); #1;
      e = q.pop_front(); total++;
      if ({ce3, core_rst3, halted3} !== {e.ce[2:0], e.core_rst, e.halted}) begin
        bad++;
        $display("FAIL bad_ch edge %0d: got ce=%b core_rst=%b halted=%b, want ce=%b core_rst=%b halted=%b",
                 n, ce3, core_rst3, halted3, e.ce[2:0], e.core_rst, e.halted);
      end
    end
    a_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cfg_ch1();
    test_cfg_clamp();
    test_halt_step();
    test_reset_mid();
    test_four_ch();
    test_bad_ch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
